operand_loader_param: RTL and testbench

//  Parametrised operand-entry/result-display peripheral for the ALU datapath. Replaces fixed 2x32-bit loader.

---
 rtl/periph_pkg.sv | 36 +++
 rtl/operand_loader_param_if.sv | 27 ++
 rtl/enter_edge_pulse.sv | 35 +++
 rtl/operand_loader_param.sv | 152 +++++++++++++++
 tb/tb_operand_loader_param.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// Shared types and helpers for the operand-entry / result-display peripheral.
package periph_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    SHOW = 2'd2
  } loader_state_t;

  // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = 7'h7f;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      4'hf: seg = 7'h0e;
      default: seg = 7'h7f;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/operand_loader_param_if.sv
// Bus between the operand loader and its surroundings (switches, button, ALU, display).
interface operand_loader_param_if #(
    parameter int DATA_W  = 32,
    parameter int IN_W    = 8,
    parameter int NUM_OPS = 2
);
    logic                        enter;
    logic [IN_W-1:0]             inputdata;
    logic                        loaddata;
    logic                        inputdata_ready;
    logic [NUM_OPS*DATA_W-1:0]   operands;
    logic [DATA_W-1:0]           dataR;
    logic [6:0]                  disp3;
    logic [6:0]                  disp2;
    logic [6:0]                  disp1;
    logic [6:0]                  disp0;

    modport master (
        output enter, inputdata, loaddata, dataR,
        input  inputdata_ready, operands, disp3, disp2, disp1, disp0
    );

    modport slave (
        input  enter, inputdata, loaddata, dataR,
        output inputdata_ready, operands, disp3, disp2, disp1, disp0
    );
endinterface

// File: rtl/enter_edge_pulse.sv
// Synchronises the raw ENTER button and emits one registered pulse per 0->1 press.
module enter_edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);
    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    // The edge detector only arms once the synchroniser carries real input and
    // has seen the button released, so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            armed     <= 1'b0;
            fill      <= 2'b00;
            pulse_out <= 1'b0;
        end else begin
            sync1     <= level_in;
            sync2     <= sync1;
            prev      <= sync2;
            fill      <= {fill[0], 1'b1};
            if (fill[1] && !sync2) begin
                armed <= 1'b1;
            end
            pulse_out <= armed & sync2 & ~prev;
        end
    end
endmodule

// File: rtl/operand_loader_param.sv
// Collects NUM_OPS operands chunk by chunk from the switches, then pages the ALU result on four digits.
module operand_loader_param
    import periph_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IN_W    = 8,
    parameter int NUM_OPS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    operand_loader_param_if.slave  bus
);
    localparam int CPO   = DATA_W / IN_W;
    localparam int OP_W  = $clog2(NUM_OPS) + 1;
    localparam int CH_W  = $clog2(CPO) + 1;
    localparam int PAGES = DATA_W / 16;
    localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;

    localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CPO - 1);
    localparam logic [PG_W-1:0] LAST_PG = PG_W'(PAGES - 1);

    loader_state_t              state;
    loader_state_t              state_nx;
    logic                       enter_pulse;
    logic                       load_q;
    logic                       load_rise;
    logic                       capture;
    logic                       last_chunk;
    logic                       last_op;
    logic [OP_W-1:0]            op_idx;
    logic [CH_W-1:0]            chunk_idx;
    logic [PG_W-1:0]            page;
    logic [NUM_OPS*DATA_W-1:0]  operands_q;
    logic [15:0]                res_page;
    logic [7:0]                 in8;
    logic [6:0]                 disp3_q, disp2_q, disp1_q, disp0_q;
    logic [6:0]                 disp3_nx, disp2_nx, disp1_nx, disp0_nx;

    enter_edge_pulse u_enter (
        .clk       (clk),
        .reset     (reset),
        .level_in  (bus.enter),
        .pulse_out (enter_pulse)
    );

    assign load_rise  = bus.loaddata & ~load_q;
    assign capture    = (state == LOAD) & enter_pulse & bus.loaddata;
    assign last_chunk = (chunk_idx == LAST_CH);
    assign last_op    = (op_idx == LAST_OP);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order between always_ff blocks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (capture && last_chunk && last_op) state_nx = DONE;
            DONE:    state_nx = SHOW;
            SHOW:    if (load_rise) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_idx    <= '0;
            chunk_idx <= '0;
            page      <= '0;
            load_q    <= 1'b0;
        end else begin
            load_q <= bus.loaddata;
            case (state)
                LOAD: begin
                    if (capture) begin
                        if (last_chunk) begin
                            chunk_idx <= '0;
                            op_idx    <= last_op ? '0 : op_idx + 1'b1;
                        end else begin
                            chunk_idx <= chunk_idx + 1'b1;
                        end
                    end
                end
                DONE: page <= '0;
                SHOW: begin
                    // A restart outranks a page step arriving in the same cycle.
                    if (load_rise) begin
                        op_idx    <= '0;
                        chunk_idx <= '0;
                    end else if (enter_pulse && !bus.loaddata) begin
                        page <= (page == LAST_PG) ? '0 : page + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand register file is cleared on reset because downstream logic
    // treats reset operands as zero; plain storage arrays normally would not be reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            operands_q <= '0;
        end else if (capture) begin
            operands_q[int'(op_idx)*DATA_W + int'(chunk_idx)*IN_W +: IN_W] <= bus.inputdata;
        end
    end

    always_comb begin
        res_page = bus.dataR[int'(page)*16 +: 16];
        in8      = 8'(bus.inputdata);
        disp3_nx = hex7seg(res_page[15:12]);
        disp2_nx = hex7seg(res_page[11:8]);
        disp1_nx = hex7seg(res_page[7:4]);
        disp0_nx = hex7seg(res_page[3:0]);
        if (state == LOAD) begin
            disp3_nx = hex7seg(4'(op_idx));
            disp2_nx = hex7seg(4'(chunk_idx));
            disp1_nx = hex7seg(in8[7:4]);
            disp0_nx = hex7seg(in8[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            disp3_q <= hex7seg(4'h0);
            disp2_q <= hex7seg(4'h0);
            disp1_q <= hex7seg(4'h0);
            disp0_q <= hex7seg(4'h0);
        end else begin
            disp3_q <= disp3_nx;
            disp2_q <= disp2_nx;
            disp1_q <= disp1_nx;
            disp0_q <= disp0_nx;
        end
    end

    assign bus.inputdata_ready = (state == DONE);
    assign bus.operands        = operands_q;
    assign bus.disp3           = disp3_q;
    assign bus.disp2           = disp2_q;
    assign bus.disp1           = disp1_q;
    assign bus.disp0           = disp0_q;
endmodule

// File: tb/tb_operand_loader_param.sv
// Directed bench: default 32x8x2 loader and a 16x4x3 variant, hand-computed expectations.
module tb_operand_loader_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    operand_loader_param_if #(.DATA_W(32), .IN_W(8), .NUM_OPS(2)) bus_a ();
    operand_loader_param_if #(.DATA_W(16), .IN_W(4), .NUM_OPS(3)) bus_b ();

    operand_loader_param #(.DATA_W(32), .IN_W(8), .NUM_OPS(2)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    operand_loader_param #(.DATA_W(16), .IN_W(4), .NUM_OPS(3)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_a    = 0;
    int rdy_b    = 0;
    int rdy_base;

    always @(negedge clk) begin
        if (bus_a.inputdata_ready === 1'b1) rdy_a++;
        if (bus_b.inputdata_ready === 1'b1) rdy_b++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
        return t[n];
    endfunction

    function automatic logic [27:0] disp_a();
        return {bus_a.disp3, bus_a.disp2, bus_a.disp1, bus_a.disp0};
    endfunction

    function automatic logic [27:0] disp_b();
        return {bus_b.disp3, bus_b.disp2, bus_b.disp1, bus_b.disp0};
    endfunction

    task automatic press_a(input logic [7:0] v, input bit timed);
        @(negedge clk);
        bus_a.inputdata = v;
        bus_a.enter     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (timed) check($sformatf("ready_edge_%0d", i), 64'(bus_a.inputdata_ready), 64'(i == 4));
        end
        bus_a.enter = 1'b0;
        @(negedge clk);
        if (timed) check("ready_one_cycle", 64'(bus_a.inputdata_ready), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic press_b(input logic [3:0] v);
        @(negedge clk);
        bus_b.inputdata = v;
        bus_b.enter     = 1'b1;
        repeat (4) @(negedge clk);
        bus_b.enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_a         = 1'b0;
        reset_b         = 1'b0;
        bus_a.enter     = 1'b1;
        bus_a.loaddata  = 1'b1;
        bus_a.inputdata = 8'h00;
        bus_a.dataR     = 32'h0;
        bus_b.enter     = 1'b0;
        bus_b.loaddata  = 1'b1;
        bus_b.inputdata = 4'h0;
        bus_b.dataR     = 16'h0;

        // Reset with enter held high.
        repeat (3) @(negedge clk);
        check("reset_ready",    64'(bus_a.inputdata_ready), 64'd0);
        check("reset_operands", bus_a.operands, 64'd0);
        check("reset_disp",     64'(disp_a()), 64'({seg(0), seg(0), seg(0), seg(0)}));

        reset_a = 1'b1;
        bus_a.inputdata = 8'h11;
        repeat (10) @(negedge clk);
        check("held_enter_no_capture", bus_a.operands, 64'd0);
        check("held_enter_chunk_idx",  64'(bus_a.disp2), 64'(seg(0)));
        check("held_enter_no_ready",   64'(rdy_a), 64'd0);
        bus_a.enter = 1'b0;
        repeat (4) @(negedge clk);

        // Straight load of 11..88.
        for (int k = 0; k < 8; k++) press_a(8'((k + 1) * 17), k == 7);
        check("load_operands", bus_a.operands, 64'h88776655_44332211);
        check("load_ready_count", 64'(rdy_a), 64'd1);

        // Result paging.
        bus_a.dataR    = 32'hDEADBEEF;
        bus_a.loaddata = 1'b0;
        repeat (3) @(negedge clk);
        check("show_page0", 64'(disp_a()), 64'({seg(4'hb), seg(4'he), seg(4'he), seg(4'hf)}));
        press_a(8'h00, 1'b0);
        check("show_page1", 64'(disp_a()), 64'({seg(4'hd), seg(4'he), seg(4'ha), seg(4'hd)}));
        press_a(8'h00, 1'b0);
        check("show_wrap", 64'(disp_a()), 64'({seg(4'hb), seg(4'he), seg(4'he), seg(4'hf)}));
        check("show_operands_kept", bus_a.operands, 64'h88776655_44332211);

        // loaddata rises in the very cycle the enter pulse is present.
        @(negedge clk);
        bus_a.inputdata = 8'h5C;
        bus_a.enter     = 1'b1;
        repeat (3) @(negedge clk);
        bus_a.loaddata = 1'b1;
        @(negedge clk);
        bus_a.enter = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_disp", 64'(disp_a()), 64'({seg(0), seg(0), seg(4'h5), seg(4'hc)}));
        check("restart_no_capture", bus_a.operands, 64'h88776655_44332211);
        check("restart_no_ready", 64'(rdy_a), 64'd1);
        press_a(8'h99, 1'b0);
        check("restart_overwrite_a0", bus_a.operands, 64'h88776655_44332299);

        // Mid-load reset.
        @(negedge clk);
        reset_a = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_ready", 64'(bus_a.inputdata_ready), 64'd0);
        reset_a = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset_operands", bus_a.operands, 64'd0);
        check("midreset_indexes", 64'({bus_a.disp3, bus_a.disp2}), 64'({seg(0), seg(0)}));

        // Paused load.
        rdy_base = rdy_a;
        for (int k = 0; k < 3; k++) press_a(8'((k + 1) * 17), 1'b0);
        check("pause_indexes", 64'({bus_a.disp3, bus_a.disp2}), 64'({seg(0), seg(3)}));
        bus_a.loaddata = 1'b0;
        press_a(8'hEE, 1'b0);
        press_a(8'hEE, 1'b0);
        check("pause_ignored_indexes", 64'({bus_a.disp3, bus_a.disp2}), 64'({seg(0), seg(3)}));
        check("pause_ignored_operands", bus_a.operands, 64'h00000000_00332211);
        bus_a.loaddata = 1'b1;
        for (int k = 3; k < 7; k++) press_a(8'((k + 1) * 17), 1'b0);
        check("pause_no_early_ready", 64'(rdy_a - rdy_base), 64'd0);
        press_a(8'h88, 1'b1);
        check("pause_operands", bus_a.operands, 64'h88776655_44332211);
        check("pause_ready_count", 64'(rdy_a - rdy_base), 64'd1);

        // 16-bit, 4-bit chunks, three operands.
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 12; k++) press_b(4'(k));
        check("b_operands", 64'(bus_b.operands), 64'h0000_CBA9_8765_4321);
        check("b_ready_count", 64'(rdy_b), 64'd1);

        @(negedge clk);
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 5; k++) press_b(4'(k));
        check("b_partial_operands", 64'(bus_b.operands), 64'h0000_0000_0005_4321);
        check("b_partial_disp", 64'(disp_b()), 64'({seg(1), seg(1), seg(0), seg(5)}));
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        check("b_reset_clears", 64'(bus_b.operands), 64'd0);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        check("b_after_reset", 64'(bus_b.operands), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
